// File: rtl/seat_pkg.sv
// Shared types and sizing for the seat-table read responder.
package seat_pkg;

    localparam int unsigned N_SEATS = 32;
    localparam int unsigned IDX_W   = 5;
    localparam int unsigned SNO_W   = 32;
    localparam int unsigned TIME_W  = 11;
    localparam int unsigned CNT_W   = 6;

    typedef enum logic [1:0] {
        ST_FREE     = 2'd0,
        ST_OCCUPIED = 2'd1,
        ST_HOLD     = 2'd2,
        ST_BANNED   = 2'd3
    } seat_state_e;

    typedef enum logic [1:0] {
        OP_SINGLE = 2'd0,
        OP_SCAN   = 2'd1,
        OP_FIND   = 2'd2,
        OP_RSVD   = 2'd3
    } rd_op_e;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RD   = 2'd1,
        S_WAIT = 2'd2,
        S_EMIT = 2'd3
    } rd_fsm_e;

    typedef struct packed {
        logic [IDX_W-1:0]  seat;
        seat_state_e       state;
        logic [SNO_W-1:0]  sno;
        logic [TIME_W-1:0] remain;
        logic              found;
        logic              last;
    } rsp_payload_t;

endpackage

// File: rtl/seat_status_reader_if.sv
// Request/response handshake bundle between a kiosk/display client and the reader.
interface seat_status_reader_if;
    import seat_pkg::*;

    logic              req_valid;
    logic              req_ready;
    logic [1:0]        req_op;
    logic [IDX_W-1:0]  req_seat;
    logic [SNO_W-1:0]  req_student;

    logic              rsp_valid;
    logic              rsp_ready;
    logic [IDX_W-1:0]  rsp_seat;
    logic [1:0]        rsp_state;
    logic [SNO_W-1:0]  rsp_sno;
    logic [TIME_W-1:0] rsp_remain;
    logic              rsp_found;
    logic              rsp_last;

    modport master (
        output req_valid, req_op, req_seat, req_student, rsp_ready,
        input  req_ready, rsp_valid, rsp_seat, rsp_state, rsp_sno,
               rsp_remain, rsp_found, rsp_last
    );

    modport slave (
        input  req_valid, req_op, req_seat, req_student, rsp_ready,
        output req_ready, rsp_valid, rsp_seat, rsp_state, rsp_sno,
               rsp_remain, rsp_found, rsp_last
    );

endinterface

// File: rtl/seat_remain_calc.sv
// Minutes left before auto-return; only occupied seats have a nonzero remainder.
module seat_remain_calc
    import seat_pkg::*;
(
    input  seat_state_e       state,
    input  logic [TIME_W-1:0] seat_time,
    input  logic [TIME_W-1:0] t_now,
    input  logic [TIME_W-1:0] limit,
    output logic [TIME_W-1:0] remain_c
);

    logic [TIME_W-1:0] elapsed;

    // Subtraction wraps across midnight by construction of the width.
    always_comb begin
        elapsed  = t_now - seat_time;
        remain_c = '0;
        if (state == ST_OCCUPIED && elapsed < limit) begin
            remain_c = limit - elapsed;
        end
    end

endmodule

// File: rtl/seat_status_reader.sv
// Read-only responder for the seat table: single-seat, full-scan and find-by-student queries.
module seat_status_reader
    import seat_pkg::*;
(
    input  logic                clk_rd,
    input  logic                rst_n_rd,
    seat_status_reader_if.slave bus,
    input  logic [TIME_W-1:0]   time_now,
    input  logic [TIME_W-1:0]   limit_time,
    output logic                tbl_en,
    output logic [IDX_W-1:0]    tbl_addr,
    input  logic [1:0]          tbl_state,
    input  logic [SNO_W-1:0]    tbl_sno,
    input  logic [TIME_W-1:0]   tbl_time,
    output logic [CNT_W-1:0]    free_cnt
);

    rd_fsm_e           state_q, state_d;
    rd_op_e            op_q, op_d;
    logic [SNO_W-1:0]  stu_q, stu_d;
    logic [TIME_W-1:0] now_q, now_d;
    logic [TIME_W-1:0] lim_q, lim_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic              skip_q, skip_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [CNT_W-1:0]  free_q, free_d;
    rsp_payload_t      rsp_q, rsp_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic              req_ready_q, req_ready_d;
    logic              tbl_en_q, tbl_en_d;
    logic [IDX_W-1:0]  tbl_addr_q, tbl_addr_d;

    logic [TIME_W-1:0] remain_c;
    logic              last_idx_c;
    rsp_payload_t      hit_c, miss_c;

    seat_remain_calc u_remain (
        .state     (seat_state_e'(tbl_state)),
        .seat_time (tbl_time),
        .t_now     (now_q),
        .limit     (lim_q),
        .remain_c  (remain_c)
    );

    assign last_idx_c = (idx_q == IDX_W'(N_SEATS - 1));

    always_comb begin
        hit_c        = '0;
        hit_c.seat   = idx_q;
        hit_c.state  = seat_state_e'(tbl_state);
        hit_c.sno    = tbl_sno;
        hit_c.remain = remain_c;
        hit_c.found  = 1'b1;
        hit_c.last   = 1'b1;
        miss_c       = '0;
        miss_c.last  = 1'b1;
    end

    // Next-state and next-output logic.
    always_comb begin
        state_d     = state_q;
        op_d        = op_q;
        stu_d       = stu_q;
        now_d       = now_q;
        lim_d       = lim_q;
        idx_d       = idx_q;
        skip_d      = skip_q;
        cnt_d       = cnt_q;
        free_d      = free_q;
        rsp_d       = rsp_q;
        rsp_valid_d = rsp_valid_q;
        req_ready_d = req_ready_q;
        tbl_en_d    = 1'b0;
        tbl_addr_d  = tbl_addr_q;

        case (state_q)
            S_IDLE: begin
                if (bus.req_valid) begin
                    op_d        = rd_op_e'(bus.req_op);
                    stu_d       = bus.req_student;
                    now_d       = time_now;
                    lim_d       = limit_time;
                    cnt_d       = '0;
                    req_ready_d = 1'b0;
                    idx_d       = '0;
                    skip_d      = 1'b0;
                    case (rd_op_e'(bus.req_op))
                        OP_SINGLE: idx_d  = bus.req_seat;
                        OP_SCAN:   idx_d  = '0;
                        OP_FIND:   skip_d = (bus.req_student == '0);
                        default:   skip_d = 1'b1;
                    endcase
                    // Degenerate requests pass through WAIT without a table access.
                    if (skip_d) begin
                        state_d = S_WAIT;
                    end else begin
                        state_d    = S_RD;
                        tbl_en_d   = 1'b1;
                        tbl_addr_d = idx_d;
                    end
                end
            end
            S_RD: begin
                state_d = S_WAIT;
            end
            S_WAIT: begin
                if (skip_q) begin
                    rsp_d       = miss_c;
                    rsp_valid_d = 1'b1;
                    state_d     = S_EMIT;
                end else if (op_q == OP_FIND && tbl_sno != stu_q) begin
                    if (last_idx_c) begin
                        rsp_d       = miss_c;
                        rsp_valid_d = 1'b1;
                        state_d     = S_EMIT;
                    end else begin
                        idx_d      = idx_q + IDX_W'(1);
                        tbl_en_d   = 1'b1;
                        tbl_addr_d = idx_d;
                        state_d    = S_RD;
                    end
                end else begin
                    rsp_d      = hit_c;
                    rsp_d.last = (op_q != OP_SCAN) || last_idx_c;
                    if (op_q == OP_SCAN && seat_state_e'(tbl_state) == ST_FREE) begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                    rsp_valid_d = 1'b1;
                    state_d     = S_EMIT;
                end
            end
            S_EMIT: begin
                if (bus.rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    if (rsp_q.last) begin
                        req_ready_d = 1'b1;
                        state_d     = S_IDLE;
                        if (op_q == OP_SCAN) begin
                            free_d = cnt_q;
                        end
                    end else begin
                        idx_d      = idx_q + IDX_W'(1);
                        tbl_en_d   = 1'b1;
                        tbl_addr_d = idx_d;
                        state_d    = S_RD;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk_rd or negedge rst_n_rd) begin
        if (!rst_n_rd) begin
            state_q     <= S_IDLE;
            op_q        <= OP_SINGLE;
            stu_q       <= '0;
            now_q       <= '0;
            lim_q       <= '0;
            idx_q       <= '0;
            skip_q      <= 1'b0;
            cnt_q       <= '0;
            free_q      <= '0;
            rsp_q       <= '0;
            rsp_valid_q <= 1'b0;
            req_ready_q <= 1'b1;
            tbl_en_q    <= 1'b0;
            tbl_addr_q  <= '0;
        end else begin
            state_q     <= state_d;
            op_q        <= op_d;
            stu_q       <= stu_d;
            now_q       <= now_d;
            lim_q       <= lim_d;
            idx_q       <= idx_d;
            skip_q      <= skip_d;
            cnt_q       <= cnt_d;
            free_q      <= free_d;
            rsp_q       <= rsp_d;
            rsp_valid_q <= rsp_valid_d;
            req_ready_q <= req_ready_d;
            tbl_en_q    <= tbl_en_d;
            tbl_addr_q  <= tbl_addr_d;
        end
    end

    assign bus.req_ready  = req_ready_q;
    assign bus.rsp_valid  = rsp_valid_q;
    assign bus.rsp_seat   = rsp_q.seat;
    assign bus.rsp_state  = rsp_q.state;
    assign bus.rsp_sno    = rsp_q.sno;
    assign bus.rsp_remain = rsp_q.remain;
    assign bus.rsp_found  = rsp_q.found;
    assign bus.rsp_last   = rsp_q.last;
    assign tbl_en         = tbl_en_q;
    assign tbl_addr       = tbl_addr_q;
    assign free_cnt       = free_q;

endmodule

// File: tb/tb_seat_status_reader.sv
// Scoreboard bench for seat_status_reader with a behavioural synchronous seat table.
module tb_seat_status_reader;
    import seat_pkg::*;

    typedef struct {
        logic [IDX_W-1:0]  seat;
        logic [1:0]        state;
        logic [SNO_W-1:0]  sno;
        logic [TIME_W-1:0] remain;
        logic              found;
        logic              last;
        int                lat;
    } exp_t;

    logic              clk_rd   = 1'b0;
    logic              rst_n_rd = 1'b0;
    logic [TIME_W-1:0] time_now = '0;
    logic [TIME_W-1:0] limit_time = '0;
    logic              tbl_en;
    logic [IDX_W-1:0]  tbl_addr;
    logic [1:0]        tbl_state = '0;
    logic [SNO_W-1:0]  tbl_sno   = '0;
    logic [TIME_W-1:0] tbl_time  = '0;
    logic [CNT_W-1:0]  free_cnt;

    logic [1:0]        mem_state [N_SEATS];
    logic [SNO_W-1:0]  mem_sno   [N_SEATS];
    logic [TIME_W-1:0] mem_time  [N_SEATS];

    exp_t sbq[$];
    int   n_vec = 0;
    int   n_err = 0;
    int   cyc = 0;
    int   acc_cyc = 0;
    int   rd_cnt = 0;
    int   rd_base = 0;
    int   stall_left = 0;
    logic [IDX_W-1:0] stall_seat = '0;

    seat_status_reader_if bus ();

    seat_status_reader dut (
        .clk_rd     (clk_rd),
        .rst_n_rd   (rst_n_rd),
        .bus        (bus),
        .time_now   (time_now),
        .limit_time (limit_time),
        .tbl_en     (tbl_en),
        .tbl_addr   (tbl_addr),
        .tbl_state  (tbl_state),
        .tbl_sno    (tbl_sno),
        .tbl_time   (tbl_time),
        .free_cnt   (free_cnt)
    );

    always #5 clk_rd = ~clk_rd;

    always @(posedge clk_rd) cyc <= cyc + 1;
    always @(negedge clk_rd) if (tbl_en) rd_cnt <= rd_cnt + 1;

    // Synchronous-read seat table.
    always @(posedge clk_rd) begin
        if (tbl_en) begin
            tbl_state <= mem_state[tbl_addr];
            tbl_sno   <= mem_sno[tbl_addr];
            tbl_time  <= mem_time[tbl_addr];
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec = n_vec + 1;
        if (act !== exp) begin
            n_err = n_err + 1;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic clear_table();
        for (int i = 0; i < int'(N_SEATS); i++) begin
            mem_state[i] = 2'd0;
            mem_sno[i]   = '0;
            mem_time[i]  = '0;
        end
    endtask

    task automatic set_seat(input int i, input logic [1:0] st, input logic [SNO_W-1:0] sno,
                            input logic [TIME_W-1:0] t);
        mem_state[i] = st;
        mem_sno[i]   = sno;
        mem_time[i]  = t;
    endtask

    task automatic push(input logic [IDX_W-1:0] seat, input logic [1:0] st, input logic [SNO_W-1:0] sno,
                        input logic [TIME_W-1:0] rem, input logic found, input logic last, input int lat);
        exp_t e;
        e.seat = seat; e.state = st; e.sno = sno; e.remain = rem;
        e.found = found; e.last = last; e.lat = lat;
        sbq.push_back(e);
    endtask

    // Present one request, then scramble every request-side input once it is accepted.
    task automatic issue(input logic [1:0] op, input logic [IDX_W-1:0] seat, input logic [SNO_W-1:0] stu,
                         input logic [TIME_W-1:0] now, input logic [TIME_W-1:0] lim);
        int n;
        @(posedge clk_rd); #1;
        rd_base         = rd_cnt;
        bus.req_valid   = 1'b1;
        bus.req_op      = op;
        bus.req_seat    = seat;
        bus.req_student = stu;
        time_now        = now;
        limit_time      = lim;
        n = 0;
        forever begin
            @(negedge clk_rd);
            if (bus.req_ready || n > 200) break;
            n++;
        end
        chk("req_ready_before_accept", 64'(bus.req_ready), 64'd1);
        @(posedge clk_rd); #1;
        acc_cyc         = cyc;
        bus.req_valid   = 1'b0;
        bus.req_op      = 2'($urandom);
        bus.req_seat    = IDX_W'($urandom);
        bus.req_student = $urandom;
        time_now        = TIME_W'($urandom);
        limit_time      = TIME_W'($urandom);
        @(negedge clk_rd);
        chk("req_ready_after_accept", 64'(bus.req_ready), 64'd0);
    endtask

    task automatic wait_done();
        int n;
        n = 0;
        while (!(sbq.size() == 0 && bus.req_ready) && n < 600) begin
            @(negedge clk_rd);
            n++;
        end
        chk("request_done", 64'(sbq.size() == 0 && bus.req_ready), 64'd1);
    endtask

    // Consumer ready: stalls a chosen seat for stall_left cycles.
    initial begin
        bus.rsp_ready = 1'b1;
        forever begin
            @(posedge clk_rd); #1;
            if (stall_left > 0 && bus.rsp_valid && bus.rsp_seat == stall_seat) begin
                bus.rsp_ready = 1'b0;
                stall_left    = stall_left - 1;
            end else begin
                bus.rsp_ready = 1'b1;
            end
        end
    end

    // Monitor: compares every accepted response against the scoreboard head.
    initial begin : monitor
        exp_t e;
        logic prev_v;
        prev_v = 1'b0;
        forever begin
            @(negedge clk_rd);
            if (rst_n_rd) begin
                if (bus.rsp_valid && !prev_v && sbq.size() > 0 && sbq[0].lat >= 0) begin
                    chk("latency", 64'(cyc - acc_cyc), 64'(sbq[0].lat));
                end
                if (bus.rsp_valid && bus.rsp_ready) begin
                    if (sbq.size() == 0) begin
                        n_vec = n_vec + 1;
                        n_err = n_err + 1;
                        $display("FAIL unexpected_rsp: got seat %0d expected no response", bus.rsp_seat);
                    end else begin
                        e = sbq.pop_front();
                        chk("rsp_seat",   64'(bus.rsp_seat),   64'(e.seat));
                        chk("rsp_state",  64'(bus.rsp_state),  64'(e.state));
                        chk("rsp_sno",    64'(bus.rsp_sno),    64'(e.sno));
                        chk("rsp_remain", 64'(bus.rsp_remain), 64'(e.remain));
                        chk("rsp_found",  64'(bus.rsp_found),  64'(e.found));
                        chk("rsp_last",   64'(bus.rsp_last),   64'(e.last));
                    end
                end
            end
            prev_v = bus.rsp_valid & rst_n_rd;
        end
    end

    initial begin : stim
        int n;
        logic [1:0]       st;
        bus.req_valid   = 1'b0;
        bus.req_op      = '0;
        bus.req_seat    = '0;
        bus.req_student = '0;
        clear_table();
        set_seat(7, 2'd1, 32'd2021001, 11'd600);

        repeat (3) @(posedge clk_rd);
        #1;
        chk("rst_req_ready", 64'(bus.req_ready), 64'd1);
        chk("rst_rsp_valid", 64'(bus.rsp_valid), 64'd0);
        chk("rst_tbl_en",    64'(tbl_en),        64'd0);
        chk("rst_free_cnt",  64'(free_cnt),      64'd0);
        chk("rst_rsp_sno",   64'(bus.rsp_sno),   64'd0);
        rst_n_rd = 1'b1;

        // SINGLE seat 7: 650-600=50 elapsed, 120-50=70 left
        push(5'd7, 2'd1, 32'd2021001, 11'd70, 1'b1, 1'b1, 2);
        issue(2'd0, 5'd7, 32'd0, 11'd650, 11'd120);
        wait_done();
        chk("single_reads", 64'(rd_cnt - rd_base), 64'd1);

        // Wrap across midnight: (10-2040) mod 2048 = 18, 30-18=12
        set_seat(3, 2'd1, 32'd77, 11'd2040);
        push(5'd3, 2'd1, 32'd77, 11'd12, 1'b1, 1'b1, 2);
        issue(2'd0, 5'd3, 32'd0, 11'd10, 11'd30);
        wait_done();

        // Elapsed equals limit -> 0
        set_seat(3, 2'd1, 32'd77, 11'd600);
        push(5'd3, 2'd1, 32'd77, 11'd0, 1'b1, 1'b1, 2);
        issue(2'd0, 5'd3, 32'd0, 11'd720, 11'd120);
        wait_done();

        // Elapsed one below limit -> 1
        push(5'd3, 2'd1, 32'd77, 11'd1, 1'b1, 1'b1, 2);
        issue(2'd0, 5'd3, 32'd0, 11'd719, 11'd120);
        wait_done();

        // Limit zero -> 0
        push(5'd7, 2'd1, 32'd2021001, 11'd0, 1'b1, 1'b1, 2);
        issue(2'd0, 5'd7, 32'd0, 11'd650, 11'd0);
        wait_done();

        // HOLD seat has no remaining time
        set_seat(5, 2'd2, 32'd2021009, 11'd600);
        push(5'd5, 2'd2, 32'd2021009, 11'd0, 1'b1, 1'b1, 2);
        issue(2'd0, 5'd5, 32'd0, 11'd650, 11'd120);
        wait_done();

        // SCAN: 0,2,4 banned, 1 occupied (640 -> 110 left), stall 5 cycles on index 3
        clear_table();
        set_seat(0, 2'd3, 32'd0, 11'd0);
        set_seat(2, 2'd3, 32'd0, 11'd0);
        set_seat(4, 2'd3, 32'd0, 11'd0);
        set_seat(1, 2'd1, 32'd2021002, 11'd640);
        for (int i = 0; i < 32; i++) begin
            st = (i == 0 || i == 2 || i == 4) ? 2'd3 : (i == 1 ? 2'd1 : 2'd0);
            push(5'(i), st, (i == 1) ? 32'd2021002 : 32'd0, (i == 1) ? 11'd110 : 11'd0,
                 1'b1, (i == 31), (i == 0) ? 2 : -1);
        end
        stall_seat = 5'd3;
        stall_left = 5;
        issue(2'd1, 5'd0, 32'd0, 11'd650, 11'd120);
        wait_done();
        chk("scan_reads", 64'(rd_cnt - rd_base), 64'd32);
        chk("scan_free_cnt", 64'(free_cnt), 64'd28);

        // FIND hit at seat 12 after 13 reads
        set_seat(12, 2'd1, 32'd2021005, 11'd600);
        push(5'd12, 2'd1, 32'd2021005, 11'd70, 1'b1, 1'b1, -1);
        issue(2'd2, 5'd0, 32'd2021005, 11'd650, 11'd120);
        wait_done();
        chk("find_hit_reads", 64'(rd_cnt - rd_base), 64'd13);

        // FIND miss after a full pass
        push(5'd0, 2'd0, 32'd0, 11'd0, 1'b0, 1'b1, -1);
        issue(2'd2, 5'd9, 32'd9999, 11'd650, 11'd120);
        wait_done();
        chk("find_miss_reads", 64'(rd_cnt - rd_base), 64'd32);

        // FIND student 0 and reserved op: answer at E1, no table access
        push(5'd0, 2'd0, 32'd0, 11'd0, 1'b0, 1'b1, 1);
        issue(2'd2, 5'd12, 32'd0, 11'd650, 11'd120);
        wait_done();
        chk("find_zero_reads", 64'(rd_cnt - rd_base), 64'd0);

        push(5'd0, 2'd0, 32'd0, 11'd0, 1'b0, 1'b1, 1);
        issue(2'd3, 5'd7, 32'd2021005, 11'd650, 11'd120);
        wait_done();
        chk("op3_reads", 64'(rd_cnt - rd_base), 64'd0);
        chk("free_cnt_kept", 64'(free_cnt), 64'd28);

        // Reset in the middle of a SCAN at index 9
        push(5'd0, 2'd3, 32'd0, 11'd0, 1'b1, 1'b0, 2);
        for (int i = 1; i < 32; i++) begin
            st = (i == 2 || i == 4) ? 2'd3 : (i == 1 ? 2'd1 : 2'd0);
            push(5'(i), st, (i == 1) ? 32'd2021002 : 32'd0, (i == 1) ? 11'd110 : 11'd0,
                 1'b1, (i == 31), -1);
        end
        issue(2'd1, 5'd0, 32'd0, 11'd650, 11'd120);
        n = 0;
        forever begin
            @(posedge clk_rd); #1;
            if ((bus.rsp_valid && bus.rsp_seat == 5'd9) || n > 300) break;
            n++;
        end
        chk("scan_reached_9", 64'(bus.rsp_valid && bus.rsp_seat == 5'd9), 64'd1);
        chk("free_cnt_mid_scan", 64'(free_cnt), 64'd28);
        #1 rst_n_rd = 1'b0;
        #1;
        chk("arst_rsp_valid", 64'(bus.rsp_valid), 64'd0);
        chk("arst_req_ready", 64'(bus.req_ready), 64'd1);
        chk("arst_free_cnt",  64'(free_cnt),      64'd0);
        chk("arst_tbl_en",    64'(tbl_en),        64'd0);
        chk("arst_rsp_seat",  64'(bus.rsp_seat),  64'd0);
        sbq.delete();
        repeat (2) @(posedge clk_rd);
        #1 rst_n_rd = 1'b1;

        // Normal SINGLE after reset
        set_seat(7, 2'd1, 32'd2021001, 11'd600);
        push(5'd7, 2'd1, 32'd2021001, 11'd70, 1'b1, 1'b1, 2);
        issue(2'd0, 5'd7, 32'd0, 11'd650, 11'd120);
        wait_done();
        chk("post_rst_reads", 64'(rd_cnt - rd_base), 64'd1);

        repeat (3) @(posedge clk_rd);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
